// File: rtl/adpll_lock_ctrl_if.sv
// Signal bundle between the ADPLL lock sequencer and its detector / loop-filter neighbours.
// The master side drives the detector observations; the slave side (the sequencer) drives the loop controls.
`timescale 1ns/1ps
interface adpll_lock_ctrl_if #(
    parameter int PW = 10
);
    logic          enable;
    logic          ref_rise;
    logic [PW-1:0] ref_period;
    logic          lead;
    logic          lag;
    logic          loop_en;
    logic [1:0]    gain_sel;
    logic          locked;
    logic          lock_lost;
    logic          fail;
    logic [2:0]    state;

    modport master (
        output enable, ref_rise, ref_period, lead, lag,
        input  loop_en, gain_sel, locked, lock_lost, fail, state
    );

    modport slave (
        input  enable, ref_rise, ref_period, lead, lag,
        output loop_en, gain_sel, locked, lock_lost, fail, state
    );
endinterface

// File: rtl/adpll_lock_ctrl.sv
// ADPLL acquisition and lock sequencer: measures reference stability and phase error per
// reference period, steps IDLE -> MEASURE -> COARSE -> FINE -> LOCKED, and flags lock loss / failure.
`timescale 1ns/1ps
module adpll_lock_ctrl #(
    parameter int PW         = 10,
    parameter int PER_TOL    = 2,
    parameter int ERR_TOL    = 2,
    parameter int COARSE_TOL = 16,
    parameter int COARSE_MIN = 16,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int TIMEOUT    = 1000
) (
    input logic              clk,
    input logic              rst,
    adpll_lock_ctrl_if.slave bus
);
    localparam int PW1 = PW + 1;
    localparam int CW  = $clog2(COARSE_MIN + 1);
    localparam int GW  = $clog2(LOCK_CNT + 1);
    localparam int BW  = $clog2(UNLOCK_CNT + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MEASURE = 3'd1;
    localparam logic [2:0] S_COARSE  = 3'd2;
    localparam logic [2:0] S_FINE    = 3'd3;
    localparam logic [2:0] S_LOCKED  = 3'd4;
    localparam logic [2:0] S_FAIL    = 3'd5;

    localparam logic [PW-1:0] CNT_MAX      = {PW{1'b1}};
    localparam logic [PW1-1:0] PER_TOL_C   = PW1'(PER_TOL);
    localparam logic [PW-1:0] ERR_TOL_C    = PW'(ERR_TOL);
    localparam logic [PW-1:0] COARSE_TOL_C = PW'(COARSE_TOL);
    localparam logic [CW-1:0] COARSE_MIN_C = CW'(COARSE_MIN);
    localparam logic [GW-1:0] LOCK_CNT_C   = GW'(LOCK_CNT);
    localparam logic [BW-1:0] UNLOCK_CNT_C = BW'(UNLOCK_CNT);
    localparam logic [TW-1:0] TIMEOUT_C    = TW'(TIMEOUT);

    function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [2:0]    state_r, state_nxt_s;
    logic [PW-1:0] err_cnt_r, wd_r, prev_period_r;
    logic          first_r, first_upd_s, first_nxt_s;
    logic [1:0]    stab_r, stab_upd_s, stab_nxt_s;
    logic [CW-1:0] per_r, per_upd_s, per_nxt_s, per_inc_s;
    logic [TW-1:0] tmo_r, tmo_upd_s, tmo_nxt_s, tmo_inc_s;
    logic [GW-1:0] good_r, good_upd_s, good_nxt_s, good_inc_s;
    logic [BW-1:0] bad_r, bad_upd_s, bad_nxt_s, bad_inc_s;
    logic          entry_s, keep_tmo_s, wd_clr_s, lost_s;
    logic          act_s, ref_lost_s, active_s, tmo_hit_s, stable_s;
    logic [PW-1:0] err_s;
    logic [PW1-1:0] diff_s, absd_s;
    logic          loop_en_r, locked_r, lock_lost_r, fail_r;
    logic [1:0]    gain_sel_r;
    logic          loop_en_nxt_s, locked_nxt_s, fail_nxt_s;
    logic [1:0]    gain_sel_nxt_s;

    assign act_s      = bus.lead | bus.lag;
    assign err_s      = err_cnt_r;
    assign ref_lost_s = (wd_r == CNT_MAX) && !bus.ref_rise;
    assign active_s   = (state_r == S_MEASURE) || (state_r == S_COARSE) ||
                        (state_r == S_FINE) || (state_r == S_LOCKED);
    assign diff_s     = {1'b0, bus.ref_period} - {1'b0, prev_period_r};
    assign absd_s     = diff_s[PW] ? (~diff_s + 1'b1) : diff_s;
    assign stable_s   = (absd_s <= PER_TOL_C);
    assign per_inc_s  = (per_r == COARSE_MIN_C) ? per_r : per_r + 1'b1;
    assign tmo_inc_s  = tmo_r + 1'b1;
    assign good_inc_s = (err_s <= ERR_TOL_C) ? good_r + 1'b1 : {GW{1'b0}};
    assign bad_inc_s  = (err_s > ERR_TOL_C) ? bad_r + 1'b1 : {BW{1'b0}};
    assign tmo_hit_s  = bus.ref_rise && ((state_r == S_COARSE) || (state_r == S_FINE)) &&
                        (tmo_inc_s == TIMEOUT_C);

    // Per-period phase error, reference watchdog and previous-period capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r     <= {PW{1'b0}};
            wd_r          <= {PW{1'b0}};
            prev_period_r <= {PW{1'b0}};
        end else begin
            if (bus.ref_rise) begin
                err_cnt_r     <= {{(PW-1){1'b0}}, act_s};
                prev_period_r <= bus.ref_period;
            end else if (act_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
            if (bus.ref_rise || wd_clr_s) begin
                wd_r <= {PW{1'b0}};
            end else begin
                wd_r <= sat_inc(wd_r);
            end
        end
    end

    // Next-state and counter update; global abort rules take precedence over state-local rules.
    always_comb begin
        state_nxt_s = state_r;
        entry_s     = 1'b0;
        keep_tmo_s  = 1'b0;
        wd_clr_s    = 1'b0;
        lost_s      = 1'b0;
        first_upd_s = first_r;
        stab_upd_s  = stab_r;
        per_upd_s   = per_r;
        tmo_upd_s   = tmo_r;
        good_upd_s  = good_r;
        bad_upd_s   = bad_r;
        if (!bus.enable) begin
            state_nxt_s = S_IDLE;
            entry_s     = 1'b1;
        end else if (ref_lost_s && active_s) begin
            state_nxt_s = S_MEASURE;
            entry_s     = 1'b1;
            wd_clr_s    = 1'b1;
            lost_s      = (state_r == S_LOCKED);
        end else if (tmo_hit_s) begin
            state_nxt_s = S_FAIL;
            entry_s     = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_nxt_s = S_MEASURE;
                    entry_s     = 1'b1;
                end
                S_MEASURE: begin
                    if (!bus.ref_rise) begin
                        stab_upd_s = stab_r;
                    end else if (!first_r) begin
                        first_upd_s = 1'b1;
                    end else if (!stable_s) begin
                        stab_upd_s = 2'd0;
                    end else if (stab_r == 2'd2) begin
                        state_nxt_s = S_COARSE;
                        entry_s     = 1'b1;
                    end else begin
                        stab_upd_s = stab_r + 2'd1;
                    end
                end
                S_COARSE: begin
                    if (!bus.ref_rise) begin
                        per_upd_s = per_r;
                    end else if ((per_inc_s >= COARSE_MIN_C) && (err_s <= COARSE_TOL_C)) begin
                        state_nxt_s = S_FINE;
                        entry_s     = 1'b1;
                        keep_tmo_s  = 1'b1;
                    end else begin
                        per_upd_s = per_inc_s;
                        tmo_upd_s = tmo_inc_s;
                    end
                end
                S_FINE: begin
                    if (!bus.ref_rise) begin
                        good_upd_s = good_r;
                    end else if (err_s > COARSE_TOL_C) begin
                        state_nxt_s = S_COARSE;
                        entry_s     = 1'b1;
                        keep_tmo_s  = 1'b1;
                    end else if (good_inc_s == LOCK_CNT_C) begin
                        state_nxt_s = S_LOCKED;
                        entry_s     = 1'b1;
                    end else begin
                        good_upd_s = good_inc_s;
                        tmo_upd_s  = tmo_inc_s;
                    end
                end
                S_LOCKED: begin
                    if (!bus.ref_rise) begin
                        bad_upd_s = bad_r;
                    end else if (bad_inc_s == UNLOCK_CNT_C) begin
                        state_nxt_s = S_COARSE;
                        entry_s     = 1'b1;
                        lost_s      = 1'b1;
                    end else if (!stable_s) begin
                        state_nxt_s = S_MEASURE;
                        entry_s     = 1'b1;
                        lost_s      = 1'b1;
                    end else begin
                        bad_upd_s = bad_inc_s;
                    end
                end
                S_FAIL: begin
                    state_nxt_s = S_FAIL;
                end
                default: begin
                    state_nxt_s = S_IDLE;
                    entry_s     = 1'b1;
                end
            endcase
        end
        // Entering any state restarts its counters; only the acquisition timeout survives COARSE<->FINE.
        first_nxt_s = entry_s ? 1'b0 : first_upd_s;
        stab_nxt_s  = entry_s ? 2'd0 : stab_upd_s;
        per_nxt_s   = entry_s ? {CW{1'b0}} : per_upd_s;
        good_nxt_s  = entry_s ? {GW{1'b0}} : good_upd_s;
        bad_nxt_s   = entry_s ? {BW{1'b0}} : bad_upd_s;
        tmo_nxt_s   = entry_s ? (keep_tmo_s ? tmo_inc_s : {TW{1'b0}}) : tmo_upd_s;
    end

    // Output decode from the upcoming state so registered outputs line up with the state register.
    always_comb begin
        loop_en_nxt_s  = 1'b0;
        gain_sel_nxt_s = 2'd0;
        locked_nxt_s   = 1'b0;
        fail_nxt_s     = 1'b0;
        case (state_nxt_s)
            S_COARSE: begin
                loop_en_nxt_s  = 1'b1;
                gain_sel_nxt_s = 2'd2;
            end
            S_FINE: begin
                loop_en_nxt_s  = 1'b1;
                gain_sel_nxt_s = 2'd1;
            end
            S_LOCKED: begin
                loop_en_nxt_s  = 1'b1;
                gain_sel_nxt_s = 2'd1;
                locked_nxt_s   = 1'b1;
            end
            S_FAIL: begin
                fail_nxt_s = 1'b1;
            end
            default: begin
                loop_en_nxt_s  = 1'b0;
                gain_sel_nxt_s = 2'd0;
            end
        endcase
    end

    // State, sequencing counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            first_r     <= 1'b0;
            stab_r      <= 2'd0;
            per_r       <= {CW{1'b0}};
            tmo_r       <= {TW{1'b0}};
            good_r      <= {GW{1'b0}};
            bad_r       <= {BW{1'b0}};
            loop_en_r   <= 1'b0;
            gain_sel_r  <= 2'd0;
            locked_r    <= 1'b0;
            lock_lost_r <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            first_r     <= first_nxt_s;
            stab_r      <= stab_nxt_s;
            per_r       <= per_nxt_s;
            tmo_r       <= tmo_nxt_s;
            good_r      <= good_nxt_s;
            bad_r       <= bad_nxt_s;
            loop_en_r   <= loop_en_nxt_s;
            gain_sel_r  <= gain_sel_nxt_s;
            locked_r    <= locked_nxt_s;
            lock_lost_r <= lost_s;
            fail_r      <= fail_nxt_s;
        end
    end

    assign bus.loop_en   = loop_en_r;
    assign bus.gain_sel  = gain_sel_r;
    assign bus.locked    = locked_r;
    assign bus.lock_lost = lock_lost_r;
    assign bus.fail      = fail_r;
    assign bus.state     = state_r;
endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Directed bench for adpll_lock_ctrl: walks acquisition, re-entry, unlock, period jump,
// reference loss, timeout and abort scenarios with hand-computed expected output vectors.
`timescale 1ns/1ps
module tb_adpll_lock_ctrl;
    // {loop_en, gain_sel[1:0], locked, lock_lost, fail, state[2:0]}
    localparam logic [8:0] O_IDLE   = 9'b0_00_0_0_0_000;
    localparam logic [8:0] O_MEAS   = 9'b0_00_0_0_0_001;
    localparam logic [8:0] O_MEAS_L = 9'b0_00_0_1_0_001;
    localparam logic [8:0] O_COAR   = 9'b1_10_0_0_0_010;
    localparam logic [8:0] O_COAR_L = 9'b1_10_0_1_0_010;
    localparam logic [8:0] O_FINE   = 9'b1_01_0_0_0_011;
    localparam logic [8:0] O_LOCK   = 9'b1_01_1_0_0_100;
    localparam logic [8:0] O_FAIL   = 9'b0_00_0_0_1_101;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [8:0] outs;

    adpll_lock_ctrl_if #(.PW(10)) bus();

    adpll_lock_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign outs = {bus.loop_en, bus.gain_sel, bus.locked, bus.lock_lost, bus.fail, bus.state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One reference period of len clk; ref_rise on the last cycle so that cycle's decision sees err = nerr.
    // mode: 0 = lead, 1 = lag, 2 = lead and lag together.
    task automatic period(input int len, input int per, input int nerr, input int mode);
        for (int i = 0; i < len; i++) begin
            bus.ref_rise   = (i == len - 1);
            bus.ref_period = 10'(per);
            bus.lead       = (i < nerr) && (mode != 1);
            bus.lag        = (i < nerr) && (mode != 0);
            cyc();
        end
        bus.ref_rise = 1'b0;
        bus.lead     = 1'b0;
        bus.lag      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.enable = 1'b0; bus.ref_rise = 1'b0; bus.ref_period = 10'd0;
        bus.lead = 1'b0; bus.lag = 1'b0;
        cyc(); cyc();
        total++; if (outs !== O_IDLE) begin bad++; $display("FAIL reset_outputs got=%b want=%b", outs, O_IDLE); end
        rst = 1'b0;
        cyc();
        total++; if (outs !== O_IDLE) begin bad++; $display("FAIL idle_disabled got=%b want=%b", outs, O_IDLE); end
    endtask

    task automatic test_ideal_lock();
        bus.enable = 1'b1;
        cyc();
        total++; if (outs !== O_MEAS) begin bad++; $display("FAIL ideal_enter_measure got=%b want=%b", outs, O_MEAS); end
        for (int k = 1; k <= 4; k++) begin
            period(100, 100, 0, 0);
            if (k == 3) begin total++; if (outs !== O_MEAS) begin bad++; $display("FAIL ideal_measure3 got=%b want=%b", outs, O_MEAS); end end
        end
        total++; if (outs !== O_COAR) begin bad++; $display("FAIL ideal_coarse got=%b want=%b", outs, O_COAR); end
        for (int k = 1; k <= 16; k++) begin
            period(100, 100, 0, 0);
            if (k == 15) begin total++; if (outs !== O_COAR) begin bad++; $display("FAIL ideal_coarse15 got=%b want=%b", outs, O_COAR); end end
        end
        total++; if (outs !== O_FINE) begin bad++; $display("FAIL ideal_fine got=%b want=%b", outs, O_FINE); end
        for (int k = 1; k <= 8; k++) begin
            period(100, 100, 0, 0);
            if (k == 7) begin total++; if (outs !== O_FINE) begin bad++; $display("FAIL ideal_fine7 got=%b want=%b", outs, O_FINE); end end
        end
        total++; if (outs !== O_LOCK) begin bad++; $display("FAIL ideal_locked got=%b want=%b", outs, O_LOCK); end
    endtask

    task automatic test_unlock();
        for (int k = 0; k < 3; k++) period(20, 100, 3, 0);
        total++; if (outs !== O_LOCK) begin bad++; $display("FAIL unlock_three_bad got=%b want=%b", outs, O_LOCK); end
        period(20, 100, 2, 0);
        total++; if (outs !== O_LOCK) begin bad++; $display("FAIL unlock_good_resets got=%b want=%b", outs, O_LOCK); end
        for (int k = 1; k <= 4; k++) begin
            period(20, 100, 3, 0);
            if (k == 3) begin total++; if (outs !== O_LOCK) begin bad++; $display("FAIL unlock_bad3 got=%b want=%b", outs, O_LOCK); end end
        end
        total++; if (outs !== O_COAR_L) begin bad++; $display("FAIL unlock_lost_pulse got=%b want=%b", outs, O_COAR_L); end
        cyc();
        total++; if (outs !== O_COAR) begin bad++; $display("FAIL unlock_pulse_end got=%b want=%b", outs, O_COAR); end
    endtask

    task automatic test_coarse_reentry();
        for (int k = 0; k < 16; k++) period(20, 100, 0, 0);
        total++; if (outs !== O_FINE) begin bad++; $display("FAIL reentry_fine got=%b want=%b", outs, O_FINE); end
        period(20, 100, 16, 2);
        total++; if (outs !== O_FINE) begin bad++; $display("FAIL both_count_once got=%b want=%b", outs, O_FINE); end
        period(30, 100, 20, 1);
        total++; if (outs !== O_COAR) begin bad++; $display("FAIL reentry_coarse got=%b want=%b", outs, O_COAR); end
        for (int k = 1; k <= 16; k++) begin
            period(20, 100, 0, 0);
            if (k == 15) begin total++; if (outs !== O_COAR) begin bad++; $display("FAIL reentry_per_restart got=%b want=%b", outs, O_COAR); end end
        end
        total++; if (outs !== O_FINE) begin bad++; $display("FAIL reentry_fine_again got=%b want=%b", outs, O_FINE); end
        for (int k = 0; k < 8; k++) period(20, 100, 0, 0);
        total++; if (outs !== O_LOCK) begin bad++; $display("FAIL reentry_relock got=%b want=%b", outs, O_LOCK); end
    endtask

    task automatic test_period_jump();
        period(20, 110, 0, 0);
        total++; if (outs !== O_MEAS_L) begin bad++; $display("FAIL jump_lost_pulse got=%b want=%b", outs, O_MEAS_L); end
        cyc();
        total++; if (outs !== O_MEAS) begin bad++; $display("FAIL jump_measure got=%b want=%b", outs, O_MEAS); end
    endtask

    task automatic test_ref_loss();
        for (int k = 0; k < 20; k++) period(20, 110, 0, 0);
        total++; if (outs !== O_FINE) begin bad++; $display("FAIL refloss_fine got=%b want=%b", outs, O_FINE); end
        for (int k = 0; k < 1023; k++) cyc();
        total++; if (outs !== O_FINE) begin bad++; $display("FAIL refloss_early got=%b want=%b", outs, O_FINE); end
        cyc();
        total++; if (outs !== O_MEAS) begin bad++; $display("FAIL refloss_measure got=%b want=%b", outs, O_MEAS); end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 4; k++) period(20, 100, 10, 0);
        total++; if (outs !== O_COAR) begin bad++; $display("FAIL timeout_coarse got=%b want=%b", outs, O_COAR); end
        for (int k = 1; k <= 1000; k++) begin
            period(20, 100, 10, 0);
            if (k == 16) begin total++; if (outs !== O_FINE) begin bad++; $display("FAIL timeout_fine got=%b want=%b", outs, O_FINE); end end
            if (k == 999) begin total++; if (outs !== O_FINE) begin bad++; $display("FAIL timeout_999 got=%b want=%b", outs, O_FINE); end end
        end
        total++; if (outs !== O_FAIL) begin bad++; $display("FAIL timeout_fail got=%b want=%b", outs, O_FAIL); end
        for (int k = 0; k < 3; k++) period(20, 100, 0, 0);
        total++; if (outs !== O_FAIL) begin bad++; $display("FAIL timeout_sticky got=%b want=%b", outs, O_FAIL); end
        bus.enable = 1'b0;
        cyc();
        total++; if (outs !== O_IDLE) begin bad++; $display("FAIL timeout_release got=%b want=%b", outs, O_IDLE); end
    endtask

    task automatic test_abort();
        bus.enable = 1'b1;
        cyc();
        for (int k = 0; k < 28; k++) period(20, 100, 0, 0);
        total++; if (outs !== O_LOCK) begin bad++; $display("FAIL abort_locked1 got=%b want=%b", outs, O_LOCK); end
        bus.enable = 1'b0; bus.ref_rise = 1'b1; bus.ref_period = 10'd150;
        cyc();
        bus.ref_rise = 1'b0;
        total++; if (outs !== O_IDLE) begin bad++; $display("FAIL abort_enable got=%b want=%b", outs, O_IDLE); end
        cyc();
        total++; if (outs !== O_IDLE) begin bad++; $display("FAIL abort_enable_hold got=%b want=%b", outs, O_IDLE); end
        bus.enable = 1'b1;
        cyc();
        for (int k = 0; k < 28; k++) period(20, 100, 0, 0);
        total++; if (outs !== O_LOCK) begin bad++; $display("FAIL abort_locked2 got=%b want=%b", outs, O_LOCK); end
        rst = 1'b1;
        cyc();
        total++; if (outs !== O_IDLE) begin bad++; $display("FAIL abort_reset got=%b want=%b", outs, O_IDLE); end
        rst = 1'b0;
        cyc();
        total++; if (outs !== O_MEAS) begin bad++; $display("FAIL abort_reset_resume got=%b want=%b", outs, O_MEAS); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ideal_lock();
        test_unlock();
        test_coarse_reentry();
        test_period_jump();
        test_ref_loss();
        test_timeout();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adpll_lock_ctrl.md
# adpll_lock_ctrl

Acquisition and lock sequencer for the ADPLL loop. Sits beside the phase detector / loop filter / DCO chain. It watches the detector's `lead`/`lag` pulses, `ref_rise` strobe and `ref_period` measurement. From these it enables the loop, selects coarse or fine loop-filter gain, declares lock, and detects loss of lock or loss of reference. All outputs are registered; the block never touches the DCO directly.

## Interface
- `PW`, 10: width of `ref_period` and of internal clk-cycle counters.
- `PER_TOL`, 2: max |Δref_period| (clk cycles) for consecutive periods to count as stable.
- `ERR_TOL`, 2: max phase-error cycles per ref period counted as "good" (fine lock).
- `COARSE_TOL`, 16: max phase-error cycles per period allowed to leave or stay out of COARSE.
- `COARSE_MIN`, 16: minimum ref periods spent in COARSE.
- `LOCK_CNT`, 8: consecutive good periods required to declare lock.
- `UNLOCK_CNT`, 4: consecutive bad periods in LOCKED that drop lock.
- `TIMEOUT`, 1000: max ref periods in COARSE+FINE before FAIL.
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `enable` in 1: level; 1 = run acquisition, 0 = return to IDLE.
- `ref_rise` in 1: one-cycle strobe per reference rising edge.
- `ref_period` in PW: last measured reference period, valid on the `ref_rise` cycle.
- `lead` in 1: detector lead indication, per clk.
- `lag` in 1: detector lag indication, per clk.
- `loop_en` out 1: loop filter/DCO correction enable.
- `gain_sel` out 2: 0 = hold, 1 = fine, 2 = coarse (3 never driven).
- `locked` out 1: high only in LOCKED.
- `lock_lost` out 1: one-cycle pulse on any exit from LOCKED except via `enable`=0.
- `fail` out 1: high in FAIL.
- `state` out 3: current state encoding, for debug.

## Operation
- Error accumulator `err_cnt` (PW bits, saturating at 2^PW−1):
  - Increments each clk where `lead|lag` (both high counts once).
  - On a `ref_rise` cycle, the pre-increment value is the evaluated error `err`. `err_cnt` then reloads to (`lead|lag`) of that cycle.
- Period stability: `stable` = |`ref_period` − `prev_period`| ≤ `PER_TOL`, with the absolute difference computed in PW+1 bits. `prev_period` updates on every `ref_rise`.
- Ref watchdog `wd` counts clk since the last `ref_rise` and clears on `ref_rise`. If it reaches 2^PW−1, `ref_lost` fires.
- States (`state` encoding):
  - IDLE (0): `loop_en`=0, `gain_sel`=0. `enable`=1 → MEASURE.
  - MEASURE (1): `loop_en`=0, `gain_sel`=0.
    - The first `ref_rise` only captures `prev_period`.
    - After that, `stab_cnt` increments on stable periods and clears otherwise.
    - `stab_cnt`=3 → COARSE; this clears `per_cnt` and `tmo_cnt`.
  - COARSE (2): `loop_en`=1, `gain_sel`=2. On each `ref_rise`, `per_cnt`++ and `tmo_cnt`++.
    - `per_cnt` ≥ `COARSE_MIN` and `err` ≤ `COARSE_TOL` → FINE; this clears `good_cnt`.
  - FINE (3): `loop_en`=1, `gain_sel`=1. On each `ref_rise`, `tmo_cnt`++.
    - `err` ≤ `ERR_TOL`: `good_cnt`++. Otherwise `good_cnt`=0.
    - `err` > `COARSE_TOL` → COARSE; this clears `per_cnt` but keeps `tmo_cnt`.
    - `good_cnt` reaching `LOCK_CNT` → LOCKED; this clears `bad_cnt`.
  - LOCKED (4): `loop_en`=1, `gain_sel`=1, `locked`=1. On each `ref_rise`:
    - `err` > `ERR_TOL` → `bad_cnt`++; otherwise `bad_cnt`=0.
    - `bad_cnt` reaching `UNLOCK_CNT` → COARSE with `lock_lost`; clears `per_cnt` and `tmo_cnt`.
    - Unstable period → MEASURE with `lock_lost`.
  - FAIL (5): `loop_en`=0, `gain_sel`=0, `fail`=1. Sticky until `enable`=0 → IDLE.
- `tmo_cnt` reaching `TIMEOUT` in COARSE/FINE → FAIL.
- Global rules and priority, highest first:
  1. `enable`=0 → IDLE from any state. No `lock_lost` pulse.
  2. `ref_lost` in MEASURE/COARSE/FINE/LOCKED → MEASURE, with `stab_cnt` and `wd` cleared. `lock_lost` pulses if leaving LOCKED.
  3. TIMEOUT → FAIL.
  4. State-local rules.
- On every state entry, all counters other than those noted are cleared.

## Timing
- Reset (`rst`=1 at a `clk` edge):
  - State IDLE; all counters and `prev_period` = 0.
  - `loop_en`=0, `gain_sel`=0, `locked`=0, `lock_lost`=0, `fail`=0, `state`=0.
- Decisions are made on the `ref_rise` cycle; the new state and outputs are visible the following cycle (latency 1).
- `enable` fall → IDLE outputs 1 cycle later, regardless of `ref_rise`.
- `lock_lost` is high for exactly the first cycle after leaving LOCKED.
- `ref_rise` coinciding with `ref_lost` in the same cycle: `ref_rise` wins and `wd` clears.
- `rst` mid-acquisition aborts immediately; no `lock_lost`.

## Test plan
- Ideal lock:
  - Stimulus: `ref_period`=100 constant, `ref_rise` every 100 clk, `lead`/`lag` low, `enable`=1.
  - Required: MEASURE for 4 ref edges, COARSE for 16, FINE for 8, then `locked`=1. `gain_sel` sequence 0→2→1.
- Coarse re-entry:
  - Stimulus: in FINE, hold `lag` high for 20 clk of one period.
  - Required: `err`=20 > 16, next state COARSE, `gain_sel`=2, `per_cnt` restarts.
- Unlock:
  - Stimulus: in LOCKED, 4 consecutive periods with `err`=3.
  - Required: `lock_lost` pulses 1 cycle, state COARSE, `locked`=0. Three bad periods followed by one good period keep lock.
- Period jump:
  - Stimulus: in LOCKED, `ref_period` 100→110.
  - Required: `lock_lost` pulse, state MEASURE, `loop_en`=0.
- Ref loss and timeout:
  - Ref loss: stop `ref_rise` in FINE → MEASURE after 1023 clk.
  - Timeout: hold `err`=10 forever → FAIL after 1000 periods, `fail` sticky until `enable`=0.
- Reset/enable abort:
  - Stimulus: assert `rst` or drop `enable` while LOCKED.
  - Required: IDLE with all outputs 0 next cycle, no `lock_lost`. Simultaneous `lead` and `lag` count 1 per cycle.
